// File: rtl/arith_pkg.sv
// Shared definitions for the bit-serial arithmetic engine.
//   - state_t  : controller FSM state (IDLE / RUN / DONE)
//   - ST_*     : fixed state encodings, so checkers can decode the state bus
//   - cnt_width: width of the bit counter for a given operand width
package arith_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

  // The counter only has to index bits 0..width-1. It never needs to hold
  // width itself, because RUN leaves on the last bit.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/fa_cell.sv
// 1-bit combinational full adder.
// Ports:
//   a, b, c : operand bits and carry-in
//   sum     : a ^ b ^ c
//   carry   : majority(a, b, c)
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder/subtractor controller. A single fa_cell is reused for
// every bit of a WIDTH-bit add or subtract, one bit per clock, LSB first.
// The carry is held in a register between cycles.
//
// Handshake: start is a one-shot request. It is accepted only in IDLE, and
// a, b, sub and cin are captured on the accepting edge. While busy, and in
// the DONE cycle, start is ignored. done pulses for exactly one cycle. sum
// and cout then stay stable until the next accepted start.
//
// Ports:
//   clk, rst : rising-edge clock, synchronous active-high reset
//   start    : operation request (sampled in IDLE only)
//   sub      : 0 = a + b + cin, 1 = a - b (cin ignored)
//   a, b     : WIDTH-bit operands
//   cin      : carry-in for add
//   busy     : high while bits are being processed
//   done     : one-cycle pulse when sum/cout are valid
//   sum      : WIDTH-bit result
//   cout     : carry-out. For subtract, 1 means no borrow (a >= b unsigned)
module serial_add_ctrl
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  logic             cell_a;
  logic             cell_b;
  logic             cell_sum;
  logic             cell_carry;
  logic             last_bit;

  assign cell_a   = a_q[cnt_q];
  assign cell_b   = b_q[cnt_q];
  assign last_bit = (cnt_q == LAST);

  fa_cell u_fa (
    .a     (cell_a),
    .b     (cell_b),
    .c     (carry_q),
    .sum   (cell_sum),
    .carry (cell_carry)
  );

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs decoded from the current state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operand capture, carry chain and result insertion.
  // Subtract is a + ~b + 1. B is inverted at capture, and the carry is
  // seeded with 1, so the cell never needs to know the operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b ^ {WIDTH{sub}};
            carry_q <= sub | cin;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
          end
        end
        RUN: begin
          sum_q[cnt_q] <= cell_sum;
          carry_q      <= cell_carry;
          if (last_bit) begin
            // Hold the counter on the last bit so it never wraps in RUN.
            cout_q <= cell_carry;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;
  import arith_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- WIDTH=8 instance ----------------
  logic       start8 = 1'b0, sub8 = 1'b0, cin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .cin(cin8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  // ---------------- WIDTH=3 instance ----------------
  logic       start3 = 1'b0, sub3 = 1'b0, cin3 = 1'b0;
  logic [2:0] a3 = '0, b3 = '0;
  logic       busy3, done3, cout3;
  logic [2:0] sum3;

  serial_add_ctrl #(.WIDTH(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .sub(sub3), .a(a3), .b(b3),
    .cin(cin3), .busy(busy3), .done(done3), .sum(sum3), .cout(cout3)
  );

  // ---------------- scoreboard ----------------
  logic [8:0] exp_q8[$];
  logic [3:0] exp_q3[$];
  int vectors     = 0;
  int miscompares = 0;
  int done8_cnt   = 0;
  int done3_cnt   = 0;
  int issued8     = 0;
  int issued3     = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pop one expected result for every done pulse. A done with nothing
  // outstanding is a spurious or duplicate pulse.
  always @(negedge clk) begin
    logic [8:0] e8;
    logic [3:0] e3;
    if (!rst && done8 === 1'b1) begin
      done8_cnt++;
      if (exp_q8.size() == 0) begin
        chk("done8_unexpected", 32'(done8), 32'd0);
      end else begin
        e8 = exp_q8.pop_front();
        chk("sum8", 32'(sum8), 32'(e8[7:0]));
        chk("cout8", 32'(cout8), 32'(e8[8]));
      end
    end
    if (!rst && done3 === 1'b1) begin
      done3_cnt++;
      if (exp_q3.size() == 0) begin
        chk("done3_unexpected", 32'(done3), 32'd0);
      end else begin
        e3 = exp_q3.pop_front();
        chk("sum3", 32'(sum3), 32'(e3[2:0]));
        chk("cout3", 32'(cout3), 32'(e3[3]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // start is raised for exactly one cycle. The task returns at the negedge
  // after the accepting edge, which is the first RUN cycle.
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic s);
    logic [8:0] r;
    @(negedge clk);
    a8 = a; b8 = b; cin8 = c; sub8 = s; start8 = 1'b1;
    if (s) r = {1'b0, a} + {1'b0, ~b} + 9'd1;
    else   r = {1'b0, a} + {1'b0, b} + {8'd0, c};
    exp_q8.push_back(r);
    issued8++;
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic issue3(input logic [2:0] a, input logic [2:0] b, input logic c, input logic s);
    logic [3:0] r;
    @(negedge clk);
    a3 = a; b3 = b; cin3 = c; sub3 = s; start3 = 1'b1;
    if (s) r = {1'b0, a} + {1'b0, ~b} + 4'd1;
    else   r = {1'b0, a} + {1'b0, b} + {3'd0, c};
    exp_q3.push_back(r);
    issued3++;
    @(negedge clk);
    start3 = 1'b0;
  endtask

  task automatic drain8();
    for (int i = 0; i < 40 && exp_q8.size() != 0; i++) @(negedge clk);
    chk("drain8_pending", 32'(exp_q8.size()), 32'd0);
    @(negedge clk);
  endtask

  task automatic drain3();
    for (int i = 0; i < 40 && exp_q3.size() != 0; i++) @(negedge clk);
    chk("drain3_pending", 32'(exp_q3.size()), 32'd0);
    @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int base;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy8", 32'(busy8), 32'd0);
    chk("rst_done8", 32'(done8), 32'd0);
    chk("rst_sum8", 32'(sum8), 32'd0);
    chk("rst_cout8", 32'(cout8), 32'd0);
    chk("rst_busy3", 32'(busy3), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic add with latency profile: busy for 8 cycles, then a single done
    issue8(8'h5A, 8'h3C, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      chk("lat_busy", 32'(busy8), 32'd1);
      chk("lat_nodone", 32'(done8), 32'd0);
      @(negedge clk);
    end
    chk("lat_done", 32'(done8), 32'd1);
    chk("lat_done_busy", 32'(busy8), 32'd0);
    @(negedge clk);
    chk("lat_done_off", 32'(done8), 32'd0);
    chk("hold_sum", 32'(sum8), 32'h96);

    // Add boundaries: full carry ripple, and carry-in ripple
    issue8(8'hFF, 8'h01, 1'b0, 1'b0); drain8();
    issue8(8'hFF, 8'h00, 1'b1, 1'b0); drain8();

    // Subtract: no borrow, then borrow (cin must be ignored)
    issue8(8'h10, 8'h01, 1'b0, 1'b1); drain8();
    issue8(8'h00, 8'h01, 1'b1, 1'b1); drain8();

    // A start pulsed during RUN and during DONE must be ignored
    issue8(8'h33, 8'h11, 1'b0, 1'b0);
    @(negedge clk); @(negedge clk);
    a8 = 8'h01; b8 = 8'h01; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    for (int i = 0; i < 20 && done8 !== 1'b1; i++) @(negedge clk);
    chk("ign_done_seen", 32'(done8), 32'd1);
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    chk("ign_idle_busy", 32'(busy8), 32'd0);
    chk("ign_idle_done", 32'(done8), 32'd0);
    repeat (12) @(negedge clk);
    chk("ign_state", 32'(dut8.state_q), 32'(IDLE));
    chk("ign_sum_held", 32'(sum8), 32'h44);
    issue8(8'h01, 8'h01, 1'b0, 1'b0); drain8();

    // Reset in the middle of an operation
    issue8(8'hAA, 8'h55, 1'b0, 1'b0);
    @(negedge clk); @(negedge clk); @(negedge clk);
    base = done8_cnt;
    rst = 1'b1;
    exp_q8.delete();
    issued8--;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", 32'(busy8), 32'd0);
    chk("mid_rst_done", 32'(done8), 32'd0);
    chk("mid_rst_sum", 32'(sum8), 32'd0);
    chk("mid_rst_cout", 32'(cout8), 32'd0);
    chk("mid_rst_state", 32'(dut8.state_q), 32'(IDLE));
    repeat (12) @(negedge clk);
    chk("mid_rst_no_done", 32'(done8_cnt), 32'(base));
    issue8(8'h12, 8'h34, 1'b1, 1'b0); drain8();

    // Randomized sweep, both widths
    for (int n = 0; n < 24; n++) begin
      issue8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      drain8();
    end
    for (int n = 0; n < 24; n++) begin
      issue3(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      drain3();
    end
    // WIDTH=3 boundaries
    issue3(3'h7, 3'h1, 1'b0, 1'b0); drain3();
    issue3(3'h0, 3'h1, 1'b0, 1'b1); drain3();

    // Exactly one done per accepted start
    repeat (5) @(negedge clk);
    chk("done8_count", 32'(done8_cnt), 32'(issued8));
    chk("done3_count", 32'(done3_cnt), 32'(issued3));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
